// File: rtl/keypad_pkg.sv
// rtl/keypad_pkg.sv - keypad scanner state encoding and key-code table
package keypad_pkg;

    typedef enum logic [1:0] {
        ST_SCAN     = 2'd0,
        ST_DEBOUNCE = 2'd1,
        ST_EMIT     = 2'd2,
        ST_HOLD     = 2'd3
    } state_t;

    // Digits use their own value; letter keys collapse to KEY_NONE.
    localparam logic [3:0] KEY_STAR  = 4'hA;
    localparam logic [3:0] KEY_ENTER = 4'hB;
    localparam logic [3:0] KEY_NONE  = 4'hF;

    function automatic logic [3:0] key_code(input logic [1:0] row, input logic [1:0] col);
        logic [3:0] code;
        case ({row, col})
            4'h0: code = 4'd1;
            4'h1: code = 4'd2;
            4'h2: code = 4'd3;
            4'h4: code = 4'd4;
            4'h5: code = 4'd5;
            4'h6: code = 4'd6;
            4'h8: code = 4'd7;
            4'h9: code = 4'd8;
            4'hA: code = 4'd9;
            4'hC: code = KEY_STAR;
            4'hD: code = 4'd0;
            4'hE: code = KEY_ENTER;
            default: code = KEY_NONE;
        endcase
        return code;
    endfunction

    function automatic logic is_digit(input logic [3:0] code);
        return (code <= 4'd9);
    endfunction

endpackage

// File: rtl/sync_2ff.sv
// rtl/sync_2ff.sv - two-flop synchroniser for asynchronous level inputs
module sync_2ff #(
    parameter int unsigned WIDTH = 4,
    parameter logic [WIDTH-1:0] RESET_VAL = '1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q
);

    logic [WIDTH-1:0] meta;

    always_ff @(posedge clk) begin
        if (!reset) begin
            meta <= RESET_VAL;
            q    <= RESET_VAL;
        end else begin
            meta <= d;
            q    <= meta;
        end
    end

endmodule

// File: rtl/keypad_scanner.sv
// rtl/keypad_scanner.sv - 4x4 keypad scan, debounce and event generation
// Optional '*' clear pulse output enabled by defining KEYPAD_CLEAR_EN.
module keypad_scanner
    import keypad_pkg::*;
#(
    parameter int unsigned SCAN_DIV       = 1000,
    parameter int unsigned DEBOUNCE_TICKS = 8
) (
    input  logic       clk,
    input  logic       reset,
    output logic [3:0] row_n,
    input  logic [3:0] col_n,
    output logic [3:0] key_in,
    output logic       key_valid,
`ifdef KEYPAD_CLEAR_EN
    output logic       clear,
`endif
    output logic       enter
);

    localparam int unsigned DIV_W = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(SCAN_DIV - 1);
    localparam logic [7:0] DB_TICKS = 8'(DEBOUNCE_TICKS);

    state_t           state_q, state_d;
    logic [DIV_W-1:0] tick_cnt;
    logic             tick;
    logic [1:0]       row_q;
    logic [1:0]       col_q;
    logic [7:0]       dcnt_q, dcnt_d;
    logic [7:0]       dcnt_inc;
    logic [3:0]       cols;
    logic             single_low;
    logic [1:0]       det_col;
    logic [3:0]       code_now;
    logic             row_adv;
    logic             latch_col;
    logic             emit_now;

    sync_2ff #(.WIDTH(4), .RESET_VAL(4'hF)) u_col_sync (
        .clk   (clk),
        .reset (reset),
        .d     (col_n),
        .q     (cols)
    );

    assign tick     = (tick_cnt == DIV_LAST);
    assign row_n    = ~(4'b0001 << row_q);
    assign dcnt_inc = dcnt_q + 8'd1;

    always_comb begin
        single_low = 1'b1;
        det_col    = 2'd0;
        case (cols)
            4'b1110: det_col = 2'd0;
            4'b1101: det_col = 2'd1;
            4'b1011: det_col = 2'd2;
            4'b0111: det_col = 2'd3;
            default: single_low = 1'b0;
        endcase
    end

    // Row is frozen outside SCAN, so row_q always names the detected key's row.
    assign code_now = key_code(row_q, det_col);

    always_comb begin
        state_d   = state_q;
        dcnt_d    = dcnt_q;
        row_adv   = 1'b0;
        latch_col = 1'b0;
        emit_now  = 1'b0;
        case (state_q)
            ST_SCAN: begin
                if (tick) begin
                    if (single_low) begin
                        latch_col = 1'b1;
                        if (DB_TICKS <= 8'd1) begin
                            state_d  = ST_EMIT;
                            emit_now = 1'b1;
                            dcnt_d   = 8'd0;
                        end else begin
                            state_d = ST_DEBOUNCE;
                            dcnt_d  = 8'd1;
                        end
                    end else begin
                        row_adv = 1'b1;
                    end
                end
            end
            ST_DEBOUNCE: begin
                if (tick) begin
                    if (single_low && (det_col == col_q)) begin
                        if (dcnt_inc >= DB_TICKS) begin
                            state_d  = ST_EMIT;
                            emit_now = 1'b1;
                            dcnt_d   = 8'd0;
                        end else begin
                            dcnt_d = dcnt_inc;
                        end
                    end else begin
                        state_d = ST_SCAN;
                        dcnt_d  = 8'd0;
                        row_adv = 1'b1;
                    end
                end
            end
            ST_EMIT: begin
                state_d = ST_HOLD;
                dcnt_d  = 8'd0;
            end
            ST_HOLD: begin
                if (tick) begin
                    if (cols == 4'b1111) begin
                        if (dcnt_inc >= DB_TICKS) begin
                            state_d = ST_SCAN;
                            dcnt_d  = 8'd0;
                        end else begin
                            dcnt_d = dcnt_inc;
                        end
                    end else begin
                        dcnt_d = 8'd0;
                    end
                end
            end
            default: begin
                state_d = ST_SCAN;
                dcnt_d  = 8'd0;
            end
        endcase
    end

    // Event outputs are registered on the accepting tick so they pulse during EMIT.
    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q   <= ST_SCAN;
            tick_cnt  <= '0;
            row_q     <= 2'd0;
            col_q     <= 2'd0;
            dcnt_q    <= 8'd0;
            key_in    <= 4'd0;
            key_valid <= 1'b0;
            enter     <= 1'b0;
`ifdef KEYPAD_CLEAR_EN
            clear     <= 1'b0;
`endif
        end else begin
            tick_cnt  <= tick ? '0 : tick_cnt + 1'b1;
            state_q   <= state_d;
            dcnt_q    <= dcnt_d;
            if (row_adv)
                row_q <= row_q + 2'd1;
            if (latch_col)
                col_q <= det_col;
            key_valid <= emit_now && is_digit(code_now);
            enter     <= emit_now && (code_now == KEY_ENTER);
            if (emit_now && is_digit(code_now))
                key_in <= code_now;
`ifdef KEYPAD_CLEAR_EN
            clear     <= emit_now && (code_now == KEY_STAR);
`endif
        end
    end

endmodule

// File: tb/tb_keypad_scanner.sv
// tb/tb_keypad_scanner.sv - scoreboard bench for keypad_scanner with a matrix keypad model
module tb_keypad_scanner;

    localparam int SD = 4;
    localparam int DT = 3;

    logic       clk;
    logic       reset;
    logic [3:0] row_n;
    logic [3:0] col_n;
    logic [3:0] key_in;
    logic       key_valid;
    logic       enter;
    logic       clear_w;

    logic [15:0] pressed;
    logic        bounce_open;

    int checks;
    int errors;
    int n_events;
    int cyc;
    logic [7:0] exp_q[$];

`ifdef KEYPAD_CLEAR_EN
    keypad_scanner #(.SCAN_DIV(SD), .DEBOUNCE_TICKS(DT)) dut (
        .clk(clk), .reset(reset), .row_n(row_n), .col_n(col_n),
        .key_in(key_in), .key_valid(key_valid), .clear(clear_w), .enter(enter)
    );
`else
    keypad_scanner #(.SCAN_DIV(SD), .DEBOUNCE_TICKS(DT)) dut (
        .clk(clk), .reset(reset), .row_n(row_n), .col_n(col_n),
        .key_in(key_in), .key_valid(key_valid), .enter(enter)
    );
    assign clear_w = 1'b0;
`endif

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Keypad model: a pressed key shorts its column low while its row is driven low.
    always_comb begin
        col_n = 4'hF;
        for (int r = 0; r < 4; r++)
            for (int c = 0; c < 4; c++)
                if (pressed[r*4+c] && !row_n[r])
                    col_n[c] = 1'b0;
        if (bounce_open)
            col_n = 4'hF;
    end

    // Kind: 1 digit, 2 enter, 3 clear, 4 illegal overlap.
    always @(negedge clk) begin
        logic [7:0] obs;
        logic [7:0] exp_w;
        if (key_valid || enter || clear_w) begin
            n_events = n_events + 1;
            obs[3:0] = key_valid ? key_in : 4'd0;
            if ((32'(key_valid) + 32'(enter) + 32'(clear_w)) > 1)
                obs[7:4] = 4'd4;
            else if (key_valid)
                obs[7:4] = 4'd1;
            else if (enter)
                obs[7:4] = 4'd2;
            else
                obs[7:4] = 4'd3;
            checks = checks + 1;
            if (exp_q.size() == 0) begin
                errors = errors + 1;
                $display("FAIL unexpected_event: got kind %0d code %0d, required no event",
                         obs[7:4], obs[3:0]);
            end else begin
                exp_w = exp_q.pop_front();
                if (obs !== exp_w) begin
                    errors = errors + 1;
                    $display("FAIL event_value: got kind %0d code %0d, required kind %0d code %0d",
                             obs[7:4], obs[3:0], exp_w[7:4], exp_w[3:0]);
                end
            end
        end
    end

    task automatic do_press(input int r, input int c, input logic exp_ev,
                            input logic [7:0] exp_w, input int hold, input string name);
        int base;
        int t0;
        bit got;
        base = n_events;
        if (exp_ev)
            exp_q.push_back(exp_w);
        @(negedge clk);
        pressed[r*4+c] = 1'b1;
        t0 = cyc;
        if (exp_ev) begin
            got = 1'b0;
            for (int i = 0; i < 400 && !got; i++) begin
                @(negedge clk);
                #1;
                if (n_events != base)
                    got = 1'b1;
            end
            checks = checks + 1;
            if (!got) begin
                errors = errors + 1;
                $display("FAIL %s_timeout: got no event in 400 cycles, required one event", name);
            end else begin
                checks = checks + 1;
                if ((cyc - t0) < 8 || (cyc - t0) > 40) begin
                    errors = errors + 1;
                    $display("FAIL %s_latency: got %0d cycles, required 8..40", name, cyc - t0);
                end
            end
        end
        repeat (hold) @(negedge clk);
        checks = checks + 1;
        if ((n_events - base) != (exp_ev ? 1 : 0)) begin
            errors = errors + 1;
            $display("FAIL %s_count: got %0d events, required %0d", name, n_events - base,
                     exp_ev ? 1 : 0);
        end
        pressed[r*4+c] = 1'b0;
        repeat (60) @(negedge clk);
    endtask

    task automatic test_reset();
        reset = 1'b0;
        repeat (5) @(posedge clk);
        @(negedge clk);
        checks = checks + 1;
        if (row_n !== 4'b1110 || key_in !== 4'd0 || key_valid !== 1'b0 || enter !== 1'b0) begin
            errors = errors + 1;
            $display("FAIL reset_state: got row_n %b key_in %0d kv %b en %b, required 1110 0 0 0",
                     row_n, key_in, key_valid, enter);
        end
        reset = 1'b1;
        @(negedge clk);
        checks = checks + 1;
        if (row_n !== 4'b1110 || key_valid !== 1'b0 || enter !== 1'b0 || clear_w !== 1'b0) begin
            errors = errors + 1;
            $display("FAIL reset_release: got row_n %b kv %b en %b clr %b, required 1110 0 0 0",
                     row_n, key_valid, enter, clear_w);
        end
        repeat (2) @(negedge clk);
        checks = checks + 1;
        if (row_n !== 4'b1110) begin
            errors = errors + 1;
            $display("FAIL row_dwell: got row_n %b after 3 clks, required 1110", row_n);
        end
        @(negedge clk);
        checks = checks + 1;
        if (row_n !== 4'b1101) begin
            errors = errors + 1;
            $display("FAIL row_step: got row_n %b after 4 clks, required 1101", row_n);
        end
        repeat (20) @(negedge clk);
    endtask

    task automatic test_hold_repeat();
        do_press(2, 0, 1'b1, {4'd1, 4'd7}, 200, "press7_hold");
        do_press(2, 0, 1'b1, {4'd1, 4'd7}, 20, "press7_again");
    endtask

    task automatic test_sequence();
        do_press(1, 0, 1'b1, {4'd1, 4'd4}, 20, "seq_4");
        do_press(0, 1, 1'b1, {4'd1, 4'd2}, 20, "seq_2");
        do_press(2, 0, 1'b1, {4'd1, 4'd7}, 20, "seq_7");
        do_press(2, 2, 1'b1, {4'd1, 4'd9}, 20, "seq_9");
        do_press(3, 2, 1'b1, {4'd2, 4'd0}, 20, "seq_enter");
        do_press(3, 1, 1'b1, {4'd1, 4'd0}, 20, "seq_0");
        checks = checks + 1;
        if (exp_q.size() != 0) begin
            errors = errors + 1;
            $display("FAIL seq_drain: got %0d pending, required 0", exp_q.size());
        end
    endtask

    task automatic test_bounce();
        int base;
        base = n_events;
        exp_q.push_back({4'd1, 4'd8});
        @(negedge clk);
        pressed[2*4+1] = 1'b1;
        for (int i = 0; i < 8; i++) begin
            bounce_open = ~bounce_open;
            repeat (5) @(negedge clk);
        end
        bounce_open = 1'b0;
        repeat (150) @(negedge clk);
        checks = checks + 1;
        if ((n_events - base) != 1) begin
            errors = errors + 1;
            $display("FAIL bounce_count: got %0d events, required 1", n_events - base);
        end
        pressed = '0;
        repeat (60) @(negedge clk);
    endtask

    task automatic test_no_event();
        int base;
        base = n_events;
        @(negedge clk);
        pressed[0] = 1'b1;
        pressed[1] = 1'b1;
        repeat (150) @(negedge clk);
        pressed = '0;
        repeat (40) @(negedge clk);
        checks = checks + 1;
        if (n_events != base) begin
            errors = errors + 1;
            $display("FAIL two_keys: got %0d events, required 0", n_events - base);
        end
        do_press(0, 3, 1'b0, 8'h00, 100, "key_A");
        do_press(3, 3, 1'b0, 8'h00, 100, "key_D");
    endtask

    task automatic test_reset_mid();
        int base;
        bit seen;
        base = n_events;
        seen = 1'b0;
        for (int i = 0; i < 100 && !seen; i++) begin
            @(negedge clk);
            if (row_n == 4'b1110) seen = 1'b1;
        end
        pressed[1*4+1] = 1'b1;
        seen = 1'b0;
        for (int i = 0; i < 100 && !seen; i++) begin
            @(negedge clk);
            if (row_n == 4'b1101) seen = 1'b1;
        end
        checks = checks + 1;
        if (!seen) begin
            errors = errors + 1;
            $display("FAIL mid_row_wait: got row_n %b, required 1101 within 100 cycles", row_n);
        end
        repeat (5) @(posedge clk);
        @(negedge clk);
        checks = checks + 1;
        if (row_n !== 4'b1101) begin
            errors = errors + 1;
            $display("FAIL mid_row_frozen: got row_n %b, required 1101", row_n);
        end
        reset = 1'b0;
        @(posedge clk);
        #1;
        checks = checks + 1;
        if (row_n !== 4'b1110 || key_valid !== 1'b0) begin
            errors = errors + 1;
            $display("FAIL mid_reset: got row_n %b kv %b, required 1110 0", row_n, key_valid);
        end
        @(negedge clk);
        pressed = '0;
        reset = 1'b1;
        repeat (80) @(negedge clk);
        checks = checks + 1;
        if (n_events != base) begin
            errors = errors + 1;
            $display("FAIL mid_reset_events: got %0d events, required 0", n_events - base);
        end
    endtask

    task automatic test_star();
`ifdef KEYPAD_CLEAR_EN
        do_press(3, 0, 1'b1, {4'd3, 4'd0}, 30, "star_clear");
`else
        do_press(3, 0, 1'b0, 8'h00, 100, "star_silent");
`endif
    endtask

    initial begin
        #2_000_000;
        $display("FAIL global_timeout: got no finish, required finish before time limit");
        $fatal(1, "timeout");
    end

    initial begin
        checks      = 0;
        errors      = 0;
        n_events    = 0;
        cyc         = 0;
        pressed     = '0;
        bounce_open = 1'b0;
        reset       = 1'b0;
        test_reset();
        test_hold_repeat();
        test_sequence();
        test_bounce();
        test_no_event();
        test_reset_mid();
        test_star();
        checks = checks + 1;
        if (exp_q.size() != 0) begin
            errors = errors + 1;
            $display("FAIL final_drain: got %0d pending, required 0", exp_q.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
